// File: rtl/sha3_padder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// sha3_padder
//
// Streaming front-end for the sha3 core. The padder collects a byte-granular
// message arriving as IN_BYTES-wide words and packs it into rate-sized blocks.
// It appends the FIPS-202 domain suffix and the pad10*1 padding, then hands
// each finished block to the core with the first message byte in the MSBs.
// The padder holds at most one block, so a stalled core stalls the input.
//
// Ports
//   clk        single clock, rising edge
//   reset_n    synchronous, active-low reset
//   mode       0 SHA3-224, 1 SHA3-256, 2 SHA3-384, 3 SHA3-512,
//              4 SHAKE128, 5 SHAKE256, 6/7 behave as 0
//   in_valid   input word valid
//   in_ready   padder can accept a word
//   in_data    message bytes, first byte in the MSBs
//   in_last    final word of the message
//   in_bytes   valid bytes on the in_last beat (0..IN_BYTES)
//   blk_valid  blk_data holds a complete block
//   blk_ready  core accepts the block
//   blk_data   block bytes, byte i at [8*MAX_RATE_BYTES-1-8i -: 8]
//   blk_last   block is the final (padded) block of the message
// -----------------------------------------------------------------------------
module sha3_padder #(
    parameter int IN_BYTES       = 8,
    parameter int MAX_RATE_BYTES = 168
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [2:0]                  mode,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [8*IN_BYTES-1:0]       in_data,
    input  logic                        in_last,
    input  logic [$clog2(IN_BYTES):0]   in_bytes,
    output logic                        blk_valid,
    input  logic                        blk_ready,
    output logic [8*MAX_RATE_BYTES-1:0] blk_data,
    output logic                        blk_last
);

    // Pointer wide enough to hold RATE itself (the "block full" value).
    localparam int PW = $clog2(MAX_RATE_BYTES + 1);
    localparam int NW = $clog2(IN_BYTES) + 1;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        EMIT   = 2'd1,
        PADBLK = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [PW-1:0]   ptr_reg, ptr_next;
    logic            pad_pending_reg, pad_pending_next;
    logic            blk_last_reg, blk_last_next;
    logic [2:0]      mode_reg, mode_next;
    logic            msg_active_reg, msg_active_next;

    logic [2:0]      eff_mode;
    logic [PW-1:0]   rate;
    logic [PW-1:0]   rate_m1;
    logic [7:0]      suffix;
    logic [NW-1:0]   n_beat;
    logic [PW-1:0]   fill_end;
    logic            beat_fire;
    logic            blk_fire;
    logic            close_last;

    // -------------------------------------------------------------------------
    // Handshakes
    // -------------------------------------------------------------------------
    assign in_ready  = reset_n && (state_reg == FILL);
    assign blk_valid = (state_reg == EMIT);
    assign blk_last  = blk_last_reg;
    assign beat_fire = in_valid && in_ready;
    assign blk_fire  = (state_reg == EMIT) && blk_ready;

    // -------------------------------------------------------------------------
    // Mode selection. The first beat of a message uses the live mode input
    // (it is latched on that same beat); every later beat, and the EMIT and
    // PADBLK states, use the latched copy so mid-message changes are ignored.
    // -------------------------------------------------------------------------
    assign eff_mode = msg_active_reg ? mode_reg : mode;

    always_comb begin
        rate   = PW'(144);
        suffix = 8'h06;
        case (eff_mode)
            3'd1: rate = PW'(136);
            3'd2: rate = PW'(104);
            3'd3: rate = PW'(72);
            3'd4: begin
                rate   = PW'(168);
                suffix = 8'h1F;
            end
            3'd5: begin
                rate   = PW'(136);
                suffix = 8'h1F;
            end
            default: begin
                rate   = PW'(144);
                suffix = 8'h06;
            end
        endcase
    end

    assign rate_m1 = rate - PW'(1);

    // Bytes carried by this beat: a full word unless it is the last beat.
    // An out-of-range in_bytes is clamped so the pointer cannot overrun.
    always_comb begin
        n_beat = NW'(IN_BYTES);
        if (in_last) begin
            if (in_bytes > NW'(IN_BYTES)) begin
                n_beat = NW'(IN_BYTES);
            end else begin
                n_beat = in_bytes;
            end
        end
    end

    assign fill_end   = ptr_reg + PW'(n_beat);
    // Last beat leaves room in the block: suffix and 0x80 go in this block.
    assign close_last = beat_fire && in_last && (fill_end < rate);

    // -------------------------------------------------------------------------
    // Control FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg       <= FILL;
            ptr_reg         <= '0;
            pad_pending_reg <= 1'b0;
            blk_last_reg    <= 1'b0;
            mode_reg        <= 3'd0;
            msg_active_reg  <= 1'b0;
        end else begin
            state_reg       <= state_next;
            ptr_reg         <= ptr_next;
            pad_pending_reg <= pad_pending_next;
            blk_last_reg    <= blk_last_next;
            mode_reg        <= mode_next;
            msg_active_reg  <= msg_active_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        ptr_next         = ptr_reg;
        pad_pending_next = pad_pending_reg;
        blk_last_next    = blk_last_reg;
        mode_next        = mode_reg;
        msg_active_next  = msg_active_reg;

        case (state_reg)
            FILL: begin
                if (beat_fire) begin
                    ptr_next = fill_end;
                    if (!msg_active_reg) begin
                        mode_next       = mode;
                        msg_active_next = 1'b1;
                    end
                    if (in_last) begin
                        state_next = EMIT;
                        if (fill_end < rate) begin
                            blk_last_next = 1'b1;
                        end else begin
                            // Message ends exactly on a block boundary: the
                            // padding needs a block of its own.
                            blk_last_next    = 1'b0;
                            pad_pending_next = 1'b1;
                        end
                    end else if (fill_end == rate) begin
                        state_next    = EMIT;
                        blk_last_next = 1'b0;
                    end
                end
            end

            EMIT: begin
                if (blk_ready) begin
                    ptr_next      = '0;
                    blk_last_next = 1'b0;
                    if (blk_last_reg) begin
                        msg_active_next = 1'b0;
                    end
                    if (pad_pending_reg) begin
                        state_next = PADBLK;
                    end else begin
                        state_next = FILL;
                    end
                end
            end

            PADBLK: begin
                blk_last_next    = 1'b1;
                pad_pending_next = 1'b0;
                state_next       = EMIT;
            end

            default: begin
                state_next = FILL;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Block buffer, one register per byte.
    // Every rate is a multiple of IN_BYTES and only the last beat can be
    // short, so the pointer is always word-aligned when a beat is written.
    // Byte gi therefore only ever takes input lane gi % IN_BYTES, and only
    // when the pointer sits at the start of its word.
    // The buffer is zeroed after each handshake, so padding can simply OR
    // into bytes that are known to be clear.
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < MAX_RATE_BYTES; gi++) begin : gen_byte
            localparam int            LANE   = gi % IN_BYTES;
            localparam logic [PW-1:0] IDX    = PW'(gi);
            localparam logic [PW-1:0] BASE   = PW'(gi - LANE);
            localparam logic [NW-1:0] LANE_W = NW'(LANE);

            logic [7:0] byte_reg;
            logic [7:0] byte_next;

            always_comb begin
                byte_next = byte_reg;
                if (blk_fire) begin
                    byte_next = 8'h00;
                end else if (state_reg == PADBLK) begin
                    if (IDX == '0) begin
                        byte_next = byte_next | suffix;
                    end
                    if (IDX == rate_m1) begin
                        byte_next = byte_next | 8'h80;
                    end
                end else if (beat_fire) begin
                    if ((ptr_reg == BASE) && (LANE_W < n_beat)) begin
                        byte_next = in_data[8*IN_BYTES-1-8*LANE -: 8];
                    end
                    // Suffix and final pad bit may land on the same byte,
                    // giving SUFFIX|0x80.
                    if (close_last && (fill_end == IDX)) begin
                        byte_next = byte_next | suffix;
                    end
                    if (close_last && (rate_m1 == IDX)) begin
                        byte_next = byte_next | 8'h80;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    byte_reg <= 8'h00;
                end else begin
                    byte_reg <= byte_next;
                end
            end

            assign blk_data[8*MAX_RATE_BYTES-1-8*gi -: 8] = byte_reg;
        end
    endgenerate

endmodule

// File: tb/tb_sha3_padder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_sha3_padder
//
// Bench for sha3_padder. Expected blocks are built from the message by a
// byte-level padding model and queued when a message is driven; a monitor
// pops and compares them as blocks are handed over. A table of messages
// covers the modes and boundaries; hand-written sequences cover output stall
// and reset in the middle of a message.
// -----------------------------------------------------------------------------
module tb_sha3_padder;

    localparam int IN_BYTES = 8;
    localparam int MRB      = 168;
    localparam int DW       = 8 * MRB;
    localparam int NV       = 12;

    logic                clk = 1'b0;
    logic                reset_n;
    logic [2:0]          mode;
    logic                in_valid;
    logic                in_ready;
    logic [8*IN_BYTES-1:0] in_data;
    logic                in_last;
    logic [3:0]          in_bytes;
    logic                blk_valid;
    logic                blk_ready;
    logic [DW-1:0]       blk_data;
    logic                blk_last;

    always #5 clk = ~clk;

    sha3_padder #(
        .IN_BYTES       (IN_BYTES),
        .MAX_RATE_BYTES (MRB)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_bytes  (in_bytes),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .blk_last  (blk_last)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } blk_t;

    typedef struct {
        logic [2:0] mode;
        int         len;
        logic [7:0] fill;
        int         sw_beat;
        logic [2:0] sw_mode;
        int         exp_blocks;
        bit         chk_gap;
    } vec_t;

    blk_t exp_q[$];
    vec_t vt[NV];

    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;
    int   recv     = 0;
    int   hs_cyc   = 0;
    int   last_gap = -1;

    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------------
    // Check helpers
    // ------------------------------------------------------------------------
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_blk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        int first;
        checks++;
        if (act !== exp) begin
            errors++;
            first = 0;
            for (int i = MRB - 1; i >= 0; i--) begin
                if (act[DW-1-8*i -: 8] !== exp[DW-1-8*i -: 8]) first = i;
            end
            $display("FAIL %s: byte %0d got %h expected %h (t=%0t)", name, first,
                     act[DW-1-8*first -: 8], exp[DW-1-8*first -: 8], $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    function automatic int rate_of(logic [2:0] m);
        case (m)
            3'd1:    return 136;
            3'd2:    return 104;
            3'd3:    return 72;
            3'd4:    return 168;
            3'd5:    return 136;
            default: return 144;
        endcase
    endfunction

    function automatic logic [7:0] sfx_of(logic [2:0] m);
        return (m == 3'd4 || m == 3'd5) ? 8'h1F : 8'h06;
    endfunction

    function automatic logic [7:0] msg_byte(int k, logic [7:0] fill);
        return (fill != 8'h00) ? fill : 8'((k * 7 + 3) & 255);
    endfunction

    // Message bytes, then the suffix byte, zeros, and 0x80 OR-ed into the
    // final byte of the final block. At least one padding byte is always
    // needed, hence len/rate + 1 blocks.
    task automatic push_expected(logic [2:0] m, int len, logic [7:0] fill);
        int r;
        int nblk;
        int idx;
        blk_t e;
        logic [7:0] v;
        r    = rate_of(m);
        nblk = len / r + 1;
        for (int b = 0; b < nblk; b++) begin
            e.data = '0;
            for (int i = 0; i < r; i++) begin
                idx = b * r + i;
                if (idx < len)       v = msg_byte(idx, fill);
                else if (idx == len) v = sfx_of(m);
                else                 v = 8'h00;
                if (b == nblk - 1 && i == r - 1) v = v | 8'h80;
                e.data[DW-1-8*i -: 8] = v;
            end
            e.last = (b == nblk - 1);
            exp_q.push_back(e);
        end
    endtask

    // ------------------------------------------------------------------------
    // Driver
    // ------------------------------------------------------------------------
    task automatic wait_accept();
        int t;
        t = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    // stop_after >= 0 abandons the message after that many accepted beats.
    task automatic send_msg(logic [2:0] m, int len, logic [7:0] fill,
                            int sw_beat, logic [2:0] sw_mode, int stop_after);
        int nb;
        int idx;
        nb   = (len == 0) ? 1 : (len + IN_BYTES - 1) / IN_BYTES;
        mode = m;
        for (int b = 0; b < nb; b++) begin
            if (b == stop_after) begin
                in_valid = 1'b0;
                in_last  = 1'b0;
                return;
            end
            if (b == sw_beat) mode = sw_mode;
            in_valid = 1'b1;
            in_last  = (b == nb - 1);
            // in_bytes is random on non-last beats, where it must be ignored.
            in_bytes = in_last ? 4'(len - b * IN_BYTES) : 4'($urandom_range(0, 8));
            for (int k = 0; k < IN_BYTES; k++) begin
                idx = b * IN_BYTES + k;
                in_data[8*IN_BYTES-1-8*k -: 8] = (idx < len) ? msg_byte(idx, fill)
                                                              : 8'($urandom);
            end
            wait_accept();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d blocks outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------------
    // Monitor: compares each handed-over block, checks in_ready the cycle
    // after a final block, and measures the gap from a handshake to the
    // next rise of blk_valid.
    // ------------------------------------------------------------------------
    initial begin : monitor
        blk_t e;
        logic prev_valid;
        logic chk_rdy;
        prev_valid = 1'b0;
        chk_rdy    = 1'b0;
        forever begin
            @(negedge clk);
            if (chk_rdy) begin
                chk("in_ready_after_last", 32'(in_ready), 32'd1);
                chk_rdy = 1'b0;
            end
            if (blk_valid === 1'b1 && !prev_valid) last_gap = cyc - hs_cyc;
            prev_valid = (blk_valid === 1'b1);
            if (blk_valid === 1'b1 && blk_ready === 1'b1) begin
                recv++;
                hs_cyc = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_block: got a block, required none (t=%0t)", $time);
                end else begin
                    e = exp_q.pop_front();
                    chk_blk("blk_data", blk_data, e.data);
                    chk("blk_last", 32'(blk_last), 32'(e.last));
                    $display("block %0d: last=%b byte0=%h (t=%0t)", recv, blk_last,
                             blk_data[DW-1 -: 8], $time);
                    if (e.last) chk_rdy = 1'b1;
                end
            end
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    int            r0;
    int            t_w;
    logic [DW-1:0] snap;

    initial begin : main
        vt[0]  = '{3'd0,   0, 8'hA5, -1, 3'd0, 1, 1'b0}; // empty SHA3-224
        vt[1]  = '{3'd0, 143, 8'hA5, -1, 3'd0, 1, 1'b0}; // suffix meets 0x80
        vt[2]  = '{3'd4, 168, 8'h00, -1, 3'd0, 2, 1'b1}; // SHAKE128 exact rate
        vt[3]  = '{3'd0,  40, 8'h00,  3, 3'd4, 1, 1'b0}; // mode change ignored
        vt[4]  = '{3'd4,  20, 8'h00, -1, 3'd0, 1, 1'b0}; // next msg uses mode 4
        vt[5]  = '{3'd1, 136, 8'h00, -1, 3'd0, 2, 1'b1}; // SHA3-256 exact rate
        vt[6]  = '{3'd2,  50, 8'h00, -1, 3'd0, 1, 1'b0}; // SHA3-384 partial
        vt[7]  = '{3'd5, 300, 8'h00, -1, 3'd0, 3, 1'b0}; // SHAKE256 3 blocks
        vt[8]  = '{3'd7,  10, 8'h00, -1, 3'd0, 1, 1'b0}; // mode 7 acts as 0
        vt[9]  = '{3'd3,  71, 8'h00, -1, 3'd0, 1, 1'b0}; // 0x86 at byte 71
        vt[10] = '{3'd4, 167, 8'h00, -1, 3'd0, 1, 1'b0}; // 0x9F at byte 167
        vt[11] = '{3'd3,  72, 8'h5A, -1, 3'd0, 2, 1'b1}; // SHA3-512 exact rate

        reset_n   = 1'b0;
        mode      = 3'd0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        in_bytes  = 4'd0;
        blk_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("in_ready_in_reset", 32'(in_ready), 32'd0);
        chk("blk_valid_in_reset", 32'(blk_valid), 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_reset", 32'(in_ready), 32'd1);
        chk("blk_valid_after_reset", 32'(blk_valid), 32'd0);
        chk("blk_last_after_reset", 32'(blk_last), 32'd0);
        chk_blk("blk_data_after_reset", blk_data, '0);
        @(posedge clk);
        #1;

        for (int v = 0; v < NV; v++) begin
            push_expected(vt[v].mode, vt[v].len, vt[v].fill);
            r0 = recv;
            send_msg(vt[v].mode, vt[v].len, vt[v].fill, vt[v].sw_beat, vt[v].sw_mode, -1);
            wait_drain();
            $display("vec %0d: mode=%0d len=%0d blocks=%0d", v, vt[v].mode, vt[v].len, recv - r0);
            chk($sformatf("vec%0d_blocks", v), 32'(recv - r0), 32'(vt[v].exp_blocks));
            if (vt[v].chk_gap) chk($sformatf("vec%0d_pad_gap", v), 32'(last_gap), 32'd2);
        end

        // SHA3-512, 100 bytes, core stalls 5 cycles on the first block.
        blk_ready = 1'b0;
        push_expected(3'd3, 100, 8'h00);
        r0 = recv;
        fork
            send_msg(3'd3, 100, 8'h00, -1, 3'd0, -1);
            begin
                t_w = 0;
                while (blk_valid !== 1'b1 && t_w < 500) begin
                    @(negedge clk);
                    t_w++;
                end
                chk("stall_block_seen", 32'(blk_valid), 32'd1);
                snap = blk_data;
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    chk("stall_valid", 32'(blk_valid), 32'd1);
                    chk_blk("stall_data_stable", blk_data, snap);
                    chk("stall_last", 32'(blk_last), 32'd0);
                    chk("stall_in_ready", 32'(in_ready), 32'd0);
                end
                @(posedge clk);
                #1 blk_ready = 1'b1;
            end
        join
        wait_drain();
        $display("stall: blocks=%0d", recv - r0);
        chk("stall_blocks", 32'(recv - r0), 32'd2);

        // Reset after 5 beats of a SHAKE128 message, then an empty SHA3-224.
        r0 = recv;
        send_msg(3'd4, 80, 8'h00, -1, 3'd0, 5);
        reset_n = 1'b0;
        @(negedge clk);
        chk("midmsg_reset_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("post_reset_blk_valid", 32'(blk_valid), 32'd0);
        chk("post_reset_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        push_expected(3'd0, 0, 8'h00);
        send_msg(3'd0, 0, 8'h00, -1, 3'd0, -1);
        wait_drain();
        $display("reset: blocks=%0d", recv - r0);
        chk("post_reset_blocks", 32'(recv - r0), 32'd1);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sha3_padder.md
Name: sha3_padder

Overview:
- Streaming front-end for the sha3 core.
- Accepts a byte-granular message as IN_BYTES-wide words over a valid/ready handshake.
- Packs the words into rate-sized blocks and applies FIPS-202 domain suffix and pad10*1 padding.
- Hands finished, MSB-first blocks to the core over a second valid/ready handshake; supports all SHA3 and SHAKE rates, so software no longer pre-pads multi-block messages.

Parameters:
- IN_BYTES, 8, input word width in bytes; legal values 1, 2, 4, 8.
- MAX_RATE_BYTES, 168, block buffer width in bytes (SHAKE128 rate); blk_data width = 8*MAX_RATE_BYTES.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- mode  in  3  0 SHA3-224 (rate 144 B), 1 SHA3-256 (136), 2 SHA3-384 (104), 3 SHA3-512 (72), 4 SHAKE128 (168), 5 SHAKE256 (136); 6/7 treated as 0.
- in_valid  in  1  input word valid.
- in_ready  out  1  padder can accept a word.
- in_data  in  8*IN_BYTES  message bytes; first byte in MSBs.
- in_last  in  1  final word of the message.
- in_bytes  in  clog2(IN_BYTES)+1  valid bytes on the in_last beat (0..IN_BYTES); ignored otherwise, where the beat counts as full.
- blk_valid  out  1  blk_data holds a complete block.
- blk_ready  in  1  core accepts the block.
- blk_data  out  8*MAX_RATE_BYTES  block bytes; byte i at bits [8*MAX_RATE_BYTES-1-8i -: 8]; bytes >= rate are zero.
- blk_last  out  1  block is the final (padded) block of the message.

Behaviour:
- Reset (reset_n low at a clk edge):
  - state=FILL, byte pointer ptr=0, buffer zeroed, blk_valid=0, blk_last=0, pad_pending=0.
  - in_ready is 0 while reset_n is low and 1 from the first cycle after release.
  - Reset mid-message or mid-EMIT discards all partial data.
- Mode latch: mode is sampled on the first accepted beat of each message (ptr==0 and no message in progress) and held until that message's blk_last block is accepted. Changes on mode mid-message are ignored. The latched mode selects RATE and SUFFIX (0x06 for SHA3, 0x1F for SHAKE).
- States:
  - FILL: in_ready=1, blk_valid=0.
    - An accepted beat writes its valid bytes at ptr..ptr+n-1; ptr += n (n = IN_BYTES, or in_bytes when in_last).
    - Non-last beat with ptr+n == RATE -> EMIT, blk_last=0.
    - Last beat with ptr+n < RATE: byte[ptr+n] |= SUFFIX, byte[RATE-1] |= 0x80 -> EMIT, blk_last=1. If these two are the same byte it becomes SUFFIX|0x80 (0x86 or 0x9F).
    - Last beat with ptr+n == RATE: -> EMIT with blk_last=0 and pad_pending=1.
  - EMIT: blk_valid=1, in_ready=0; blk_data and blk_last are held stable.
    - On blk_valid && blk_ready: buffer cleared, ptr=0.
    - If pad_pending: next state PADBLK. Otherwise FILL.
  - PADBLK: single cycle. Builds an all-zero block with byte0=SUFFIX and byte[RATE-1]=0x80, sets blk_last=1, clears pad_pending -> EMIT.
- Latency:
  - A block is valid the cycle after the beat that completes it.
  - The extra pad block is valid 2 cycles after the preceding block's handshake.
  - in_ready reasserts the cycle after an accepted blk_last block.
- Empty message: a last beat with in_bytes=0 at ptr=0 yields one block, SUFFIX at byte0 and 0x80 at RATE-1.
- The padder never holds more than one block; backpressure on blk_ready stalls the input.
- Since every RATE is a multiple of 8, full beats never straddle a block boundary.

Test Plan:
- SHA3-224 (mode 0), empty message (in_last, in_bytes=0) -> one block, blk_last=1; blk_data[1343:1336]=0x06, blk_data[199:192]=0x80, all other bits 0.
- SHA3-224, 143-byte message of 0xA5 (17 full beats plus a 7-byte last beat) -> one block; bytes 0..142=0xA5, byte143=0x86, bytes 144..167=0.
- SHAKE128 (mode 4), 168-byte message -> block 1 holds the data with blk_last=0; then block 2 with byte0=0x1F, byte167=0x80, blk_last=1, valid 2 cycles after the first handshake.
- SHA3-512 (mode 3), 100-byte message, blk_ready held low 5 cycles -> block 1 (72 B, last=0) stable and in_ready=0 throughout the stall; block 2 has bytes 0..27 data, byte28=0x06, byte71=0x80, last=1.
- mode switched from 0 to 4 after beat 3 of a SHA3-224 message -> rate stays 144 and suffix stays 0x06; the next message picks up mode 4.
- reset_n pulsed low for 1 cycle after 5 beats -> blk_valid=0, in_ready=1 the next cycle; a fresh empty message yields exactly the empty-message block.
